// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Converts a simple SRAM-style core data port into single-beat AXI
//   transactions. Only one transaction is in flight at a time. The core is
//   held off with stallreq until the transaction finishes.
//
// Ports
//   clk, resetn                 : rising-edge clock, async active-low reset
//   data_sram_en/wen/addr/wdata : core request (wen == 0 means a read)
//   data_sram_rdata             : last loaded word, held until the next read
//   stallreq                    : core must hold its request while high
//   ar*/r*                      : AXI read address and read data channels
//   aw*/w*/b*                   : AXI write address, data and response channels
module sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int          ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [31:0]       data_sram_wdata,
  output logic [31:0]       data_sram_rdata,
  output logic              stallreq,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wen_q, wen_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              aw_hs, w_hs;

  // Response IDs, response codes and rlast carry no information for a
  // single-beat, single-outstanding master, so they are deliberately dropped.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  // Fixed single-beat, 32-bit, incrementing burst attributes.
  assign arid    = AXI_ID;
  assign awid    = AXI_ID;
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arsize  = 3'b010;
  assign awsize  = 3'b010;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;

  // Channel controls decode straight from state so that reset clears them
  // immediately. The done flags let AW and W retire independently.
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);
  assign awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign bready  = (state_q == WR_RESP);
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;

  assign data_sram_rdata = rdata_q;

  // Stall in the request cycle itself and for every busy state. DONE is the
  // one cycle where the core sees the result and is free to move on.
  assign stallreq = ((state_q == IDLE) && data_sram_en) ||
                    ((state_q != IDLE) && (state_q != DONE));

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Next-state logic: capture the request in IDLE, then walk through the
  // read or write channel sequence. Both write handshakes may complete in
  // the same cycle, so the flag and the live handshake are ORed.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (data_sram_en) begin
          addr_d  = data_sram_addr;
          wdata_d = data_sram_wdata;
          wen_d   = data_sram_wen;
          state_d = (data_sram_wen == 4'b0000) ? RD_ADDR : WR_REQ;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      WR_RESP: begin
        if (bvalid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured registers. Reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge
//   Directed bench for sram_axi_bridge. The AXI slave side is driven by hand
//   from each scenario task; expected values are written out per cycle.
module tb_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors = 0;
  int checks = 0;

  sram_axi_bridge #(.AXI_ID(4'd1), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq(stallreq),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    data_sram_en = 1'b0;
    settle();
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_en0 got=%b exp=0", stallreq); end
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_handshakes got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready});
    end
    checks++;
    if (data_sram_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got=%h exp=0", data_sram_rdata); end
    data_sram_en = 1'b1;
    settle();
    checks++;
    if (stallreq !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_en1 got=%b exp=1", stallreq); end
    checks++;
    if ({arid, awid, arlen, awlen, arsize, awsize, arburst, awburst, wlast} !==
        {4'd1, 4'd1, 8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1}) begin
      errors++;
      $display("[TB] FAIL constants got=%h_%h_%h_%h_%b_%b_%b_%b_%b exp=1_1_00_00_010_010_01_01_1",
               arid, awid, arlen, awlen, arsize, awsize, arburst, awburst, wlast);
    end
    data_sram_en = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // Zero-wait read: AR accepted immediately, R data one cycle later.
  task automatic test_read(input logic [31:0] addr, input logic [31:0] data, input string tag);
    int stallCycles;
    stallCycles = 0;
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = addr;
    data_sram_wdata = 32'hFFFF_FFFF; arready = 1'b1; rvalid = 1'b0;
    settle();
    if (stallreq === 1'b1) stallCycles++;
    tick();
    checks++;
    if (arvalid !== 1'b1 || araddr !== addr) begin
      errors++; $display("[TB] FAIL %s_ar got=%b/%h exp=1/%h", tag, arvalid, araddr, addr);
    end
    if (stallreq === 1'b1) stallCycles++;
    tick();
    checks++;
    if (rready !== 1'b1 || arvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_rready got=%b/%b exp=1/0", tag, rready, arvalid);
    end
    if (stallreq === 1'b1) stallCycles++;
    rvalid = 1'b1; rdata = data; rid = 4'hA; rresp = 2'b10; rlast = 1'b1;
    tick();
    checks++;
    if (stallreq !== 1'b0 || data_sram_rdata !== data || rready !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_done got=%b/%h/%b exp=0/%h/0", tag, stallreq, data_sram_rdata, rready, data);
    end
    checks++;
    if (stallCycles != 3) begin errors++; $display("[TB] FAIL %s_stall_cycles got=%0d exp=3", tag, stallCycles); end
    data_sram_en = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    tick();
    checks++;
    if (stallreq !== 1'b0 || arvalid !== 1'b0 || data_sram_rdata !== data) begin
      errors++; $display("[TB] FAIL %s_idle got=%b/%b/%h exp=0/0/%h", tag, stallreq, arvalid, data_sram_rdata, data);
    end
  endtask

  // Write with W accepted on the first cycle and AW held off for 3 cycles.
  task automatic test_write();
    data_sram_en = 1'b1; data_sram_wen = 4'b0011; data_sram_addr = 32'h0000_0100;
    data_sram_wdata = 32'h1234_5678; awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    tick();
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b110 || wstrb !== 4'b0011 ||
        wdata !== 32'h1234_5678 || awaddr !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL wr_cycle1 got=%b%b%b/%b/%h/%h exp=110/0011/12345678/00000100",
               awvalid, wvalid, bready, wstrb, wdata, awaddr);
    end
    tick();
    checks++;
    if ({awvalid, wvalid, bready, stallreq} !== 4'b1001 || awaddr !== 32'h0000_0100) begin
      errors++; $display("[TB] FAIL wr_cycle2 got=%b%b%b%b/%h exp=1001/00000100", awvalid, wvalid, bready, stallreq, awaddr);
    end
    tick();
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      errors++; $display("[TB] FAIL wr_cycle3 got=%b%b%b exp=100", awvalid, wvalid, bready);
    end
    awready = 1'b1;
    tick();
    checks++;
    if ({awvalid, wvalid, bready, stallreq} !== 4'b0011) begin
      errors++; $display("[TB] FAIL wr_resp got=%b%b%b%b exp=0011", awvalid, wvalid, bready, stallreq);
    end
    awready = 1'b0; bvalid = 1'b1; bresp = 2'b11; bid = 4'h7;
    tick();
    checks++;
    if (stallreq !== 1'b0 || bready !== 1'b0 || data_sram_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL wr_done got=%b/%b/%h exp=0/0/deadbeef", stallreq, bready, data_sram_rdata);
    end
    data_sram_en = 1'b0; bvalid = 1'b0;
    tick();
  endtask

  // Read then write with the enable held across DONE.
  task automatic test_back_to_back();
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0200;
    arready = 1'b1; rvalid = 1'b0;
    tick();
    tick();
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    rvalid = 1'b0;
    data_sram_wen = 4'b1111; data_sram_addr = 32'h0000_0300; data_sram_wdata = 32'hA5A5_A5A5;
    settle();
    checks++;
    if (stallreq !== 1'b0 || awvalid !== 1'b0 || arvalid !== 1'b0 || data_sram_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("[TB] FAIL b2b_done got=%b/%b/%b/%h exp=0/0/0/cafef00d", stallreq, awvalid, arvalid, data_sram_rdata);
    end
    tick();
    checks++;
    if (stallreq !== 1'b1 || awvalid !== 1'b0 || arvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_idle got=%b/%b/%b exp=1/0/0", stallreq, awvalid, arvalid);
    end
    tick();
    checks++;
    if ({awvalid, wvalid, arvalid} !== 3'b110 || wstrb !== 4'b1111 || awaddr !== 32'h0000_0300 || wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("[TB] FAIL b2b_wr got=%b%b%b/%b/%h/%h exp=110/1111/00000300/a5a5a5a5",
                         awvalid, wvalid, arvalid, wstrb, awaddr, wdata);
    end
    awready = 1'b1; wready = 1'b1;
    tick();
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      errors++; $display("[TB] FAIL b2b_same_cycle got=%b%b%b exp=001", awvalid, wvalid, bready);
    end
    awready = 1'b0; bvalid = 1'b1;
    tick();
    checks++;
    if (stallreq !== 1'b0 || data_sram_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("[TB] FAIL b2b_wr_done got=%b/%h exp=0/cafef00d", stallreq, data_sram_rdata);
    end
    data_sram_en = 1'b0; bvalid = 1'b0;
    tick();
  endtask

  // Reset in RD_DATA aborts the read; a fresh read then completes.
  task automatic test_reset_mid();
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0400;
    arready = 1'b1; rvalid = 1'b0;
    tick();
    tick();
    checks++;
    if (rready !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre got=%b exp=1", rready); end
    resetn = 1'b0;
    settle();
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0 || stallreq !== 1'b1 || data_sram_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL mid_reset got=%b/%b/%h exp=00000/1/0",
                         {arvalid, rready, awvalid, wvalid, bready}, stallreq, data_sram_rdata);
    end
    data_sram_en = 1'b0;
    settle();
    checks++;
    if (stallreq !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle got=%b exp=0", stallreq); end
    tick();
    resetn = 1'b1;
    tick();
    test_read(32'h0000_0500, 32'h0BAD_F00D, "after_reset");
  endtask

  // AR held off for 10 cycles: address and valid must stay put.
  task automatic test_arready_stall();
    int bad;
    bad = 0;
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0600;
    arready = 1'b0; rvalid = 1'b0;
    tick();
    data_sram_addr = 32'hFFFF_0000;
    for (int i = 0; i < 10; i++) begin
      if (arvalid !== 1'b1 || araddr !== 32'h0000_0600 || stallreq !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("[TB] FAIL ar_hold bad_cycles=%0d exp=0", bad); end
    arready = 1'b1;
    tick();
    rvalid = 1'b1; rdata = 32'h600D_600D;
    tick();
    checks++;
    if (data_sram_rdata !== 32'h600D_600D || stallreq !== 1'b0) begin
      errors++; $display("[TB] FAIL ar_hold_done got=%h/%b exp=600d600d/0", data_sram_rdata, stallreq);
    end
    data_sram_en = 1'b0; rvalid = 1'b0; arready = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0; data_sram_en = 1'b0; data_sram_wen = 4'b0; data_sram_addr = 32'h0;
    data_sram_wdata = 32'h0; arready = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b0;
    rlast = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'h0;
    bresp = 2'b0; bvalid = 1'b0;
    #2;
    test_reset();
    test_read(32'h1FC0_0000, 32'hDEAD_BEEF, "read");
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_arready_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameters SHALL be, one per line:
- AXI_ID, 4'd1, ID driven on arid/awid.
- ADDR_W, 32, address width.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge.
- resetn, in, 1, asynchronous active-low reset.
- data_sram_en, in, 1, core request strobe.
- data_sram_wen, in, 4, byte write enables; 0 = read.
- data_sram_addr, in, 32, physical byte address.
- data_sram_wdata, in, 32, store data.
- data_sram_rdata, out, 32, load data.
- stallreq, out, 1, core must hold its request while high.
- arid/araddr/arlen/arsize/arburst/arvalid, out, 4/32/8/3/2/1, AXI read address.
- arready, in, 1.
- rid/rdata/rresp/rlast/rvalid, in, 4/32/2/1/1, AXI read data.
- rready, out, 1.
- awid/awaddr/awlen/awsize/awburst/awvalid, out, 4/32/8/3/2/1, AXI write address.
- awready, in, 1.
- wdata/wstrb/wlast/wvalid, out, 32/4/1/1, AXI write data.
- wready, in, 1.
- bid/bresp/bvalid, in, 4/2/1, AXI write response.
- bready, out, 1.
REQ-003 Constant outputs SHALL be: arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01, wlast=1, arid=awid=AXI_ID.

Function
REQ-004 States SHALL be: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-005 In IDLE with data_sram_en=1:
- capture addr, wdata and wen.
- go to RD_ADDR if wen==0, else WR_REQ.
REQ-006 stallreq SHALL be combinational: stallreq = (IDLE & data_sram_en) | (state not in {IDLE, DONE}); it SHALL be 0 in DONE.
REQ-007 RD_ADDR:
- arvalid=1 and araddr=captured address.
- on arvalid&arready, go to RD_DATA.
REQ-008 RD_DATA:
- rready=1.
- on rvalid, register rdata into data_sram_rdata and go to DONE.
- rresp and rid are ignored.
REQ-009 WR_REQ:
- awvalid and wvalid assert together; each deasserts independently after its own handshake and is tracked by a done flag.
- wstrb=captured wen.
- go to WR_RESP when both handshakes have completed, including the same cycle.
REQ-010 WR_RESP:
- bready=1.
- on bvalid, go to DONE.
- bresp is ignored.
REQ-011 DONE SHALL last exactly one cycle, ignore data_sram_en, and return to IDLE.
REQ-012 data_sram_rdata SHALL hold its last loaded value until the next read completes; writes leave it unchanged.
REQ-013 Only one transaction SHALL be outstanding at a time; a new request is accepted no earlier than the cycle after DONE.
REQ-014 Minimum latency with zero-wait slaves SHALL be:
- read: request cycle, RD_ADDR, RD_DATA, DONE (stall released 3 cycles after request).
- write: request cycle, WR_REQ, WR_RESP, DONE.
REQ-015 Valid signals SHALL remain asserted, with stable payload, until their handshake completes.

Reset
REQ-016 With resetn=0 the block SHALL reset asynchronously:
- state=IDLE.
- all valid/ready outputs, done flags, captured registers and data_sram_rdata = 0.
- stallreq = data_sram_en.
REQ-017 Reset asserted mid-transaction SHALL abort the transaction without a response; the slave is reset together with the bridge.

Verification
REQ-018 Read at 0x1FC0_0000, arready=1, rvalid one cycle after AR with rdata=0xDEADBEEF -> stallreq high 3 cycles, then rdata=0xDEADBEEF in DONE.
REQ-019 Write with wen=4'b0011, wdata=0x12345678, awready delayed 3 cycles, wready=1 immediately -> wvalid drops after 1 cycle, awvalid holds 3 cycles, wstrb=0011, bready only after both handshakes complete.
REQ-020 Back-to-back read then write with en held -> the second request is accepted only after DONE; never two outstanding transactions.
REQ-021 resetn pulled low in RD_DATA -> all valids low immediately and state IDLE; a subsequent read completes normally.
REQ-022 arready low 10 cycles -> araddr stable and arvalid held throughout, stallreq high throughout.
